// File: rtl/rr_capture_arbiter.sv
// Round-robin arbiter that shares one 1-bit capture register among N_REQ requesters.
// A requester wins a slot, its data bit is captured, then it is presented with q_valid for HOLD_CYCLES cycles.
module rr_capture_arbiter #(
  parameter int N_REQ       = 4,
  parameter int HOLD_CYCLES = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ-1:0]         din,
  output logic [N_REQ-1:0]         gnt,
  output logic                     q,
  output logic                     q_valid,
  output logic [$clog2(N_REQ)-1:0] q_src,
  output logic                     busy
);

  localparam int PW = $clog2(N_REQ);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_CAPTURE = 2'd1;
  localparam logic [1:0] S_HOLD    = 2'd2;

  logic [1:0]       state;
  logic [PW-1:0]    ptr;
  logic [PW-1:0]    win;
  logic [7:0]       hold_cnt;
  logic [PW-1:0]    pick;
  logic [N_REQ-1:0] pick_onehot;
  int               idx;
  logic             found;

  // First set request at or above ptr, wrapping around to index 0.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = PW'(idx);
      end
    end
    pick_onehot = N_REQ'(1) << pick;
  end

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      gnt      <= '0;
      q        <= 1'b0;
      q_valid  <= 1'b0;
      q_src    <= '0;
      ptr      <= '0;
      win      <= '0;
      hold_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req != '0) begin
            gnt   <= pick_onehot;
            win   <= pick;
            state <= S_CAPTURE;
          end
        end
        // The grant is committed: din is taken from the winner even if its req has dropped.
        S_CAPTURE: begin
          q        <= din[win];
          q_src    <= win;
          q_valid  <= 1'b1;
          gnt      <= '0;
          ptr      <= (win == PW'(N_REQ - 1)) ? '0 : win + 1'b1;
          hold_cnt <= 8'(HOLD_CYCLES - 1);
          state    <= S_HOLD;
        end
        S_HOLD: begin
          if (hold_cnt == 8'd0) begin
            q_valid <= 1'b0;
            state   <= S_IDLE;
          end else begin
            hold_cnt <= hold_cnt - 8'd1;
          end
        end
        default: begin
          gnt     <= '0;
          q_valid <= 1'b0;
          state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_capture_arbiter.sv
// Scoreboard bench for rr_capture_arbiter (N_REQ=4, HOLD_CYCLES=2).
// Stimulus pushes expected grants/captures; a negedge monitor pops and compares them.
module tb_rr_capture_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = '0;
  logic [3:0] din = '0;
  logic [3:0] gnt;
  logic       q;
  logic       q_valid;
  logic [1:0] q_src;
  logic       busy;

  typedef struct {
    logic       q;
    logic [1:0] src;
  } cap_t;

  logic [3:0] exp_gnt[$];
  cap_t       exp_cap[$];
  int         checks = 0;
  int         errors = 0;
  logic       prev_qv = 1'b0;

  rr_capture_arbiter #(.N_REQ(4), .HOLD_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .din(din),
    .gnt(gnt), .q(q), .q_valid(q_valid), .q_src(q_src), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input logic [3:0] r, input logic [3:0] d);
    req = r;
    din = d;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    apply_stimulus(4'($urandom), 4'($urandom));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    apply_stimulus(4'b0000, 4'b0000);
  endtask

  task automatic wait_grant();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (gnt != 4'b0000) return;
    end
    check_output("grant_timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!busy) return;
    end
    check_output("idle_timeout", 32'd1, 32'd0);
  endtask

  // Monitor: every grant and every new capture must match the head of its queue.
  always @(negedge clk) begin
    if (gnt != 4'b0000) begin
      if (exp_gnt.size() == 0) check_output("unexpected_gnt", 32'(gnt), 32'd0);
      else check_output("gnt", 32'(gnt), 32'(exp_gnt.pop_front()));
    end
    if (q_valid && !prev_qv) begin
      if (exp_cap.size() == 0) begin
        check_output("unexpected_capture", 32'd1, 32'd0);
      end else begin
        cap_t c;
        c = exp_cap.pop_front();
        check_output("cap_q", 32'(q), 32'(c.q));
        check_output("cap_src", 32'(q_src), 32'(c.src));
      end
    end
    prev_qv = q_valid;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset with random inputs
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(4'($urandom), 4'($urandom));
      @(negedge clk);
      check_output("rst_gnt", 32'(gnt), 32'd0);
      check_output("rst_q", 32'(q), 32'd0);
      check_output("rst_qv", 32'(q_valid), 32'd0);
      check_output("rst_src", 32'(q_src), 32'd0);
      check_output("rst_busy", 32'(busy), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    apply_stimulus(4'b0000, 4'b0000);

    // Single request, cycle-accurate timing
    @(negedge clk);
    apply_stimulus(4'b0100, 4'b0100);
    exp_gnt.push_back(4'b0100);
    exp_cap.push_back('{q: 1'b1, src: 2'd2});
    @(negedge clk);
    check_output("t2_gnt_c1", 32'(gnt), 32'h4);
    check_output("t2_busy_c1", 32'(busy), 32'd1);
    apply_stimulus(4'b0000, 4'b0100);
    @(negedge clk);
    check_output("t2_qv_c2", 32'(q_valid), 32'd1);
    check_output("t2_q_c2", 32'(q), 32'd1);
    check_output("t2_src_c2", 32'(q_src), 32'd2);
    @(negedge clk);
    check_output("t2_qv_c3", 32'(q_valid), 32'd1);
    @(negedge clk);
    check_output("t2_qv_c4", 32'(q_valid), 32'd0);
    check_output("t2_busy_c4", 32'(busy), 32'd0);
    check_output("t2_q_hold_c4", 32'(q), 32'd1);

    // All requesting: rotation 0,1,2,3,0 with 4-cycle spacing
    do_reset();
    apply_stimulus(4'b1111, 4'b1010);
    exp_gnt.push_back(4'b0001); exp_cap.push_back('{q: 1'b0, src: 2'd0});
    exp_gnt.push_back(4'b0010); exp_cap.push_back('{q: 1'b1, src: 2'd1});
    exp_gnt.push_back(4'b0100); exp_cap.push_back('{q: 1'b0, src: 2'd2});
    exp_gnt.push_back(4'b1000); exp_cap.push_back('{q: 1'b1, src: 2'd3});
    exp_gnt.push_back(4'b0001); exp_cap.push_back('{q: 1'b0, src: 2'd0});
    wait_grant();
    for (int k = 0; k < 4; k++) begin
      repeat (3) @(negedge clk);
      check_output("t3_gap_idle", 32'(gnt), 32'd0);
      @(negedge clk);
      check_output("t3_spacing", 32'(gnt != 4'b0000), 32'd1);
    end
    apply_stimulus(4'b0000, 4'b1010);
    wait_idle();

    // Wrap-around after a grant to requester 3
    do_reset();
    apply_stimulus(4'b1000, 4'b0001);
    exp_gnt.push_back(4'b1000); exp_cap.push_back('{q: 1'b0, src: 2'd3});
    exp_gnt.push_back(4'b0001); exp_cap.push_back('{q: 1'b1, src: 2'd0});
    exp_gnt.push_back(4'b0010); exp_cap.push_back('{q: 1'b0, src: 2'd1});
    wait_grant();
    apply_stimulus(4'b0011, 4'b0001);
    wait_grant();
    wait_grant();
    apply_stimulus(4'b0000, 4'b0001);
    wait_idle();

    // Asynchronous reset during HOLD
    do_reset();
    apply_stimulus(4'b0100, 4'b0100);
    exp_gnt.push_back(4'b0100); exp_cap.push_back('{q: 1'b1, src: 2'd2});
    wait_grant();
    apply_stimulus(4'b0000, 4'b0100);
    @(negedge clk);
    check_output("t5_qv_before", 32'(q_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_output("t5_qv_async", 32'(q_valid), 32'd0);
    check_output("t5_q_async", 32'(q), 32'd0);
    check_output("t5_busy_async", 32'(busy), 32'd0);
    check_output("t5_src_async", 32'(q_src), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    apply_stimulus(4'b1010, 4'b1010);
    exp_gnt.push_back(4'b0010); exp_cap.push_back('{q: 1'b1, src: 2'd1});
    wait_grant();
    apply_stimulus(4'b0000, 4'b1010);
    wait_idle();

    // Request dropped during CAPTURE still captures
    do_reset();
    apply_stimulus(4'b0010, 4'b0010);
    exp_gnt.push_back(4'b0010); exp_cap.push_back('{q: 1'b1, src: 2'd1});
    wait_grant();
    apply_stimulus(4'b0000, 4'b0010);
    @(negedge clk);
    check_output("t6_qv", 32'(q_valid), 32'd1);
    wait_idle();

    repeat (3) @(negedge clk);
    check_output("gnt_queue_drained", 32'(exp_gnt.size()), 32'd0);
    check_output("cap_queue_drained", 32'(exp_cap.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
